// File: rtl/serial_demux_pkg.sv
// Shared types and constants for the parameterised serial demultiplexer.
package serial_demux_pkg;

  typedef enum logic [2:0] {
    IDLE, ADDR, LEN, DATA, PARITY, STOP, ERR, WAIT_IDLE
  } state_t;

  localparam logic [1:0] ERR_LEN0   = 2'd0;
  localparam logic [1:0] ERR_CHDIS  = 2'd1;
  localparam logic [1:0] ERR_PARITY = 2'd2;
  localparam logic [1:0] ERR_STOP   = 2'd3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/serial_demux_shifter.sv
// Bit counter plus shift register shared by the address, length and data fields.
// o_fld is the field value including the bit sampled this cycle, so the
// owner can capture it in the same cycle that o_done strobes.
module serial_demux_shifter #(
  parameter int SW = 8,
  parameter int CW = $clog2(SW + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clr,
  input  logic          i_en,
  input  logic          i_bit,
  input  logic          i_lsb_first,
  input  logic [CW-1:0] i_nbits,
  output logic [SW-1:0] o_fld,
  output logic          o_done
);

  logic [SW-1:0] r_data;
  logic [CW-1:0] r_cnt;
  logic [SW-1:0] w_next;

  // LSB-first fields drop each bit at its own index; MSB-first shifts left.
  always_comb begin
    w_next = r_data;
    if (i_lsb_first) begin
      for (int i = 0; i < SW; i++)
        if (r_cnt == CW'(i)) w_next[i] = i_bit;
    end else begin
      w_next = {r_data[SW-2:0], i_bit};
    end
  end

  assign o_done = i_en && (r_cnt == i_nbits - CW'(1));
  assign o_fld  = w_next;

  // Count bits of the current field; restart from zero after each field.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_data <= '0;
    end else if (i_clr || o_done) begin
      r_cnt  <= '0;
      r_data <= '0;
    end else if (i_en) begin
      r_cnt  <= r_cnt + CW'(1);
      r_data <= w_next;
    end
  end

endmodule

// File: rtl/serial_demux_param.sv
// Framed serial receiver routing payload words to one of N_CH channels,
// with parity/stop checking, channel-enable mask and error recovery.
module serial_demux_param
  import serial_demux_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int ADDR_W = $clog2(N_CH),
  parameter int LEN_W  = 4,
  parameter int WORD_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   serIn,
  input  logic [N_CH-1:0]        ch_en,
  output logic [N_CH*WORD_W-1:0] ch_data,
  output logic [N_CH-1:0]        ch_valid,
  output logic                   busy,
  output logic                   frame_ok,
  output logic                   error,
  output logic [1:0]             err_code
);

  localparam int SW = max3(ADDR_W, LEN_W, WORD_W);
  localparam int CW = $clog2(SW + 1);

  state_t                         r_state, w_state_n;
  logic [ADDR_W-1:0]              r_addr;
  logic [LEN_W-1:0]               r_len;
  logic                           r_par;
  logic [N_CH-1:0][WORD_W-1:0]    r_ch_data;
  logic [N_CH-1:0]                r_ch_valid;
  logic                           r_frame_ok;
  logic [1:0]                     r_err_code;

  logic          w_sh_en, w_done, w_load, w_err, w_ok;
  logic [CW-1:0] w_nbits;
  logic [SW-1:0] w_fld;
  logic [1:0]    w_code;
  logic [ADDR_W-1:0] w_addr_fld;

  assign w_addr_fld = w_fld[ADDR_W-1:0];

  // Field width and bit order follow the state that owns the shifter.
  always_comb begin
    w_sh_en = (r_state == ADDR) || (r_state == LEN) || (r_state == DATA);
    w_nbits = CW'(WORD_W);
    if (r_state == ADDR) w_nbits = CW'(ADDR_W);
    else if (r_state == LEN) w_nbits = CW'(LEN_W);
  end

  serial_demux_shifter #(.SW(SW), .CW(CW)) u_shifter (
    .i_clk       (clk),
    .i_rst_n     (reset),
    .i_clr       (r_state == IDLE),
    .i_en        (w_sh_en),
    .i_bit       (serIn),
    .i_lsb_first (r_state != DATA),
    .i_nbits     (w_nbits),
    .o_fld       (w_fld),
    .o_done      (w_done)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_n;
  end

  // Next state plus strobes for word load, error entry and frame completion.
  always_comb begin
    w_state_n = r_state;
    w_load    = 1'b0;
    w_err     = 1'b0;
    w_ok      = 1'b0;
    w_code    = ERR_LEN0;
    case (r_state)
      IDLE: if (!serIn) w_state_n = ADDR;
      ADDR: if (w_done) begin
        if (!ch_en[w_addr_fld]) begin
          w_state_n = ERR; w_err = 1'b1; w_code = ERR_CHDIS;
        end else w_state_n = LEN;
      end
      LEN: if (w_done) begin
        if (w_fld[LEN_W-1:0] == '0) begin
          w_state_n = ERR; w_err = 1'b1; w_code = ERR_LEN0;
        end else w_state_n = DATA;
      end
      DATA: if (w_done) begin
        w_load = 1'b1;
        if (r_len == LEN_W'(1)) w_state_n = PARITY;
      end
      PARITY: begin
        if (r_par ^ serIn) begin
          w_state_n = ERR; w_err = 1'b1; w_code = ERR_PARITY;
        end else w_state_n = STOP;
      end
      STOP: begin
        if (serIn) begin
          w_state_n = IDLE; w_ok = 1'b1;
        end else begin
          w_state_n = ERR; w_err = 1'b1; w_code = ERR_STOP;
        end
      end
      ERR:       w_state_n = WAIT_IDLE;
      WAIT_IDLE: if (serIn) w_state_n = IDLE;
      default:   w_state_n = IDLE;
    endcase
  end

  // Frame datapath: header capture, running parity, word delivery, status.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr     <= '0;
      r_len      <= '0;
      r_par      <= 1'b0;
      r_ch_data  <= '0;
      r_ch_valid <= '0;
      r_frame_ok <= 1'b0;
      r_err_code <= ERR_LEN0;
    end else begin
      r_ch_valid <= '0;
      r_frame_ok <= w_ok;
      if (r_state == IDLE) r_par <= 1'b0;
      else if (w_sh_en)    r_par <= r_par ^ serIn;
      if (r_state == ADDR && w_done) r_addr <= w_addr_fld;
      if (r_state == LEN && w_done)  r_len  <= w_fld[LEN_W-1:0];
      if (w_load) begin
        r_ch_data[r_addr]  <= w_fld[WORD_W-1:0];
        r_ch_valid[r_addr] <= 1'b1;
        r_len              <= r_len - LEN_W'(1);
      end
      if (w_err) r_err_code <= w_code;
    end
  end

  assign ch_data  = r_ch_data;
  assign ch_valid = r_ch_valid;
  assign frame_ok = r_frame_ok;
  assign error    = (r_state == ERR);
  assign busy     = (r_state != IDLE);
  assign err_code = r_err_code;

endmodule
